// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// Bus read word layout: [7:0] byte, [8] valid, [9] overrun, [10] framing error.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_POP,
    R_RESP
  } rd_state_t;

  localparam int RX_VALID_BIT   = 8;
  localparam int RX_OVERRUN_BIT = 9;
  localparam int RX_FRAME_BIT   = 10;

  // Clocks per oversample tick for an 8x oversampled receiver.
  function automatic int default_prescale(input int clk_hz, input int baud);
    return clk_hz / (baud * 8);
  endfunction

endpackage

// File: rtl/uart_rx_deserializer.sv
// Synchronises the serial line, times bit centres with a down-counter and
// shifts in 8N1 frames; pulses byte_valid or frame_err when the stop bit is sampled.
module uart_rx_deserializer
  import uart_pkg::*;
#(
  parameter int PRESCALE = default_prescale(50000000, 9600)
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int CW = $clog2(PRESCALE * 8);
  localparam logic [CW-1:0] HALF_LOAD = CW'(PRESCALE * 4 - 1);
  localparam logic [CW-1:0] BIT_LOAD  = CW'(PRESCALE * 8 - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  logic            rx_meta_reg;
  logic            rx_s_reg;
  rx_state_t       state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [2:0]      bit_idx_reg, bit_idx_next;
  logic [7:0]      shift_reg, shift_next;
  logic            tick;

  // Both sync flops reset to the idle level so reset never fakes a start bit.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      rx_meta_reg <= 1'b1;
      rx_s_reg    <= 1'b1;
    end else begin
      rx_meta_reg <= rx;
      rx_s_reg    <= rx_meta_reg;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      bit_idx_reg <= bit_idx_next;
      shift_reg   <= shift_next;
    end
  end

  assign tick      = (cnt_reg == '0);
  assign byte_data = shift_reg;

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    bit_idx_next = bit_idx_reg;
    shift_next   = shift_reg;
    byte_valid   = 1'b0;
    frame_err    = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (!rx_s_reg) begin
          state_next = START;
          cnt_next   = HALF_LOAD;
        end
      end
      START: begin
        if (!tick) begin
          cnt_next = cnt_reg - CNT_ONE;
        end else if (rx_s_reg) begin
          state_next = IDLE;
        end else begin
          state_next   = DATA;
          bit_idx_next = '0;
          cnt_next     = BIT_LOAD;
        end
      end
      DATA: begin
        if (!tick) begin
          cnt_next = cnt_reg - CNT_ONE;
        end else begin
          shift_next   = {rx_s_reg, shift_reg[7:1]};
          cnt_next     = BIT_LOAD;
          bit_idx_next = bit_idx_reg + 3'd1;
          if (bit_idx_reg == 3'd7) state_next = STOP;
        end
      end
      STOP: begin
        if (!tick) begin
          cnt_next = cnt_reg - CNT_ONE;
        end else if (rx_s_reg) begin
          byte_valid = 1'b1;
          state_next = IDLE;
        end else begin
          frame_err  = 1'b1;
          state_next = BREAK;
        end
      end
      BREAK: begin
        if (rx_s_reg) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: deserialiser feeding a circular byte buffer that the CPU
// drains through a request/ready read handshake, with sticky error flags.
module uart_rx
  import uart_pkg::*;
#(
  parameter int PRESCALE = default_prescale(50000000, 9600),
  parameter int DEPTH    = 16
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_request,
  output logic [31:0] o_rdata,
  output logic        o_ready,
  input  logic        UART_RX
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic           byte_valid;
  logic [7:0]     byte_data;
  logic           frame_err;

  logic [7:0]     mem [DEPTH];
  logic [AW-1:0]  wr_ptr_reg;
  logic [AW-1:0]  rd_ptr_reg;
  logic [AW:0]    count_reg;
  logic           overrun_reg;
  logic           frame_reg;
  rd_state_t      rd_state_reg, rd_state_next;
  logic [7:0]     rd_byte_reg;
  logic           rd_valid_reg;
  logic           rd_overrun_reg;
  logic           rd_frame_reg;

  logic           full;
  logic           pop;
  logic           push;
  logic           overrun_set;
  logic           flag_clr;

  uart_rx_deserializer #(
    .PRESCALE (PRESCALE)
  ) u_deser (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .rx         (UART_RX),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .frame_err  (frame_err)
  );

  assign full        = (count_reg == FULL_COUNT);
  assign flag_clr    = (rd_state_reg == R_POP);
  assign pop         = flag_clr && (count_reg != '0);
  // A pop in the same cycle frees a slot, so a full buffer can still accept.
  assign push        = byte_valid && (!full || pop);
  assign overrun_set = byte_valid && full && !pop;

  always_ff @(posedge i_clock) begin
    if (push) mem[wr_ptr_reg] <= byte_data;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      unique case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Set has priority over the clear issued by a pop in the same cycle.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      overrun_reg <= 1'b0;
      frame_reg   <= 1'b0;
    end else begin
      overrun_reg <= overrun_set | (overrun_reg & ~flag_clr);
      frame_reg   <= frame_err | (frame_reg & ~flag_clr);
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      rd_state_reg   <= R_IDLE;
      rd_byte_reg    <= '0;
      rd_valid_reg   <= 1'b0;
      rd_overrun_reg <= 1'b0;
      rd_frame_reg   <= 1'b0;
    end else begin
      rd_state_reg <= rd_state_next;
      if (flag_clr) begin
        rd_byte_reg    <= pop ? mem[rd_ptr_reg] : 8'h00;
        rd_valid_reg   <= pop;
        rd_overrun_reg <= overrun_reg;
        rd_frame_reg   <= frame_reg;
      end
    end
  end

  always_comb begin
    rd_state_next = rd_state_reg;
    o_ready       = 1'b0;
    unique case (rd_state_reg)
      R_IDLE: if (i_request) rd_state_next = R_POP;
      R_POP:  rd_state_next = R_RESP;
      R_RESP: begin
        o_ready = i_request;
        if (!i_request) rd_state_next = R_IDLE;
      end
      default: rd_state_next = R_IDLE;
    endcase
  end

  always_comb begin
    o_rdata                 = '0;
    o_rdata[7:0]            = rd_byte_reg;
    o_rdata[RX_VALID_BIT]   = rd_valid_reg;
    o_rdata[RX_OVERRUN_BIT] = rd_overrun_reg;
    o_rdata[RX_FRAME_BIT]   = rd_frame_reg;
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: serial frames in, bus reads out, hand-computed
// expected words for the single-byte, empty, glitch, framing, overrun and reset cases.
module tb_uart_rx;

  localparam int PRESCALE = 4;
  localparam int DEPTH    = 16;
  localparam int BIT      = PRESCALE * 8;

  logic        i_clock = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_request = 1'b0;
  logic [31:0] o_rdata;
  logic        o_ready;
  logic        UART_RX = 1'b1;

  int n_total = 0;
  int n_bad   = 0;

  uart_rx #(
    .PRESCALE (PRESCALE),
    .DEPTH    (DEPTH)
  ) dut (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .i_request (i_request),
    .o_rdata   (o_rdata),
    .o_ready   (o_ready),
    .UART_RX   (UART_RX)
  );

  always #5 i_clock = ~i_clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input int extra_low);
    @(negedge i_clock);
    UART_RX = 1'b0;
    repeat (BIT) @(negedge i_clock);
    for (int i = 0; i < 8; i++) begin
      UART_RX = b[i];
      repeat (BIT) @(negedge i_clock);
    end
    UART_RX = stop;
    repeat (BIT + extra_low) @(negedge i_clock);
    UART_RX = 1'b1;
  endtask

  task automatic do_read(input string tag, input logic [31:0] exp, input int hold);
    int lat;
    @(negedge i_clock);
    i_request = 1'b1;
    lat = 0;
    while (!o_ready && lat < 20) begin
      @(negedge i_clock);
      lat++;
    end
    chk({tag, ".lat"}, 32'(lat), 32'd2);
    chk({tag, ".data"}, o_rdata, exp);
    if (hold > 0) begin
      repeat (hold) @(negedge i_clock);
      chk({tag, ".hold_rdy"}, {31'b0, o_ready}, 32'd1);
      chk({tag, ".hold_data"}, o_rdata, exp);
    end
    i_request = 1'b0;
    @(negedge i_clock);
    chk({tag, ".drop"}, {31'b0, o_ready}, 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge i_clock);
    i_reset = 1'b0;
    chk("reset.ready", {31'b0, o_ready}, 32'd0);
    chk("reset.rdata", o_rdata, 32'h0);

    // Empty buffer, request held long: one response, nothing consumed.
    do_read("empty", 32'h0000_0000, 10);

    send_frame(8'hA5, 1'b1, 0);
    do_read("single", 32'h0000_01A5, 2);
    do_read("single.after", 32'h0000_0000, 0);

    // Low pulse shorter than half a bit must not start a frame.
    @(negedge i_clock);
    UART_RX = 1'b0;
    repeat (8) @(negedge i_clock);
    UART_RX = 1'b1;
    repeat (2 * BIT) @(negedge i_clock);
    send_frame(8'h3C, 1'b1, 0);
    do_read("glitch", 32'h0000_013C, 0);
    do_read("glitch.after", 32'h0000_0000, 0);

    send_frame(8'h5A, 1'b0, 100);
    repeat (BIT) @(negedge i_clock);
    send_frame(8'h55, 1'b1, 0);
    do_read("frame", 32'h0000_0555, 0);
    do_read("frame.after", 32'h0000_0000, 0);

    for (int i = 0; i <= 16; i++) send_frame(8'(i), 1'b1, 0);
    do_read("ovr.first", 32'h0000_0300, 0);
    for (int i = 1; i < 16; i++) do_read($sformatf("ovr.%0d", i), 32'h100 | 32'(i), 0);
    do_read("ovr.empty", 32'h0000_0000, 0);

    // Leave a byte buffered, then reset during data bit 3 of 0x81.
    send_frame(8'h11, 1'b1, 0);
    send_frame(8'h22, 1'b1, 0);
    do_read("pre_rst", 32'h0000_0111, 0);
    @(negedge i_clock);
    UART_RX = 1'b0;
    repeat (BIT) @(negedge i_clock);
    for (int i = 0; i < 3; i++) begin
      UART_RX = (i == 0);
      repeat (BIT) @(negedge i_clock);
    end
    UART_RX = 1'b0;
    repeat (BIT / 2) @(negedge i_clock);
    i_reset = 1'b1;
    @(negedge i_clock);
    i_reset = 1'b0;
    UART_RX = 1'b1;
    chk("rst.ready", {31'b0, o_ready}, 32'd0);
    chk("rst.rdata", o_rdata, 32'h0);
    repeat (12 * BIT) @(negedge i_clock);
    do_read("rst.read", 32'h0000_0000, 0);
    send_frame(8'h7E, 1'b1, 0);
    do_read("rst.clean", 32'h0000_017E, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver that pairs with the UART transmitter on the same peripheral bus. It samples the asynchronous `UART_RX` line at 8× the baud rate and deserialises 8N1 frames. Completed bytes go into an internal circular buffer, and the CPU drains them through the same request/ready bus handshake the transmitter uses. Framing errors and overruns are recorded as sticky status bits.

## Interface
- `PRESCALE`, default 50000000/(9600*8): clocks per oversample tick. One bit time is PRESCALE*8 clocks.
- `DEPTH`, default 16: receive buffer entries. Must be a power of two, 2..256.
- `i_clock  in  1`: the only clock.
- `i_reset  in  1`: synchronous, active-high reset.
- `i_request  in  1`: bus read request. Held high until `o_ready`, then dropped.
- `o_rdata  out  32`: read response. [7:0] byte, [8] valid, [9] overrun, [10] framing error, [31:11] zero.
- `o_ready  out  1`: read response valid. Held high while `i_request` stays high.
- `UART_RX  in  1`: asynchronous serial input. Idles high.

## Operation
- **Input sync:** `UART_RX` passes through 2 flops, both reset to 1. All receive logic uses only the synchronised value `rx_s`.
- **Tick counter:** a counter of width $clog2(PRESCALE*8) loads and decrements per state. It is cleared on reset.
- **Receive FSM:**
  - IDLE:
    - `rx_s`==0 → START, load PRESCALE*4-1.
  - START, on counter 0:
    - `rx_s`==1 → false start, return to IDLE.
    - `rx_s`==0 → DATA, bit index 0, load PRESCALE*8-1.
  - DATA, on counter 0:
    - Shift `rx_s` in LSB-first and reload.
    - After bit 7 → STOP.
  - STOP, on counter 0:
    - `rx_s`==1 → push byte, go to IDLE.
    - `rx_s`==0 → set framing flag, discard byte, go to BREAK.
  - BREAK: wait for `rx_s`==1, then go to IDLE.
- **Push rules:**
  - Buffer full with no pop in the same cycle → byte dropped, overrun flag set.
  - Push and pop in the same cycle → both take effect, count unchanged.
- **Read FSM:**
  - R_IDLE:
    - `i_request` high → R_POP.
  - R_POP:
    - Latch head byte, valid=(count≠0), and both flags into `o_rdata`.
    - Advance the read pointer only if count≠0.
    - Clear both flags → R_RESP.
  - R_RESP:
    - `o_ready`=1 while `i_request` is high.
    - `i_request` low → `o_ready`=0, go to R_IDLE.
- **Empty buffer:** a read returns valid=0 and byte 0. Reads never block.
- **Flag race:** a flag set in the same cycle as the clearing pop stays set. Set wins.
- **Reset values:**
  - `o_ready`=0, `o_rdata`=0.
  - Pointers, count and flags = 0.
  - Both FSMs in IDLE; the shift register is cleared.
  - Reset mid-frame abandons the frame.

## Timing
- **Read latency:** `i_request` sampled high in cycle N → pop in N+1 → `o_rdata`/`o_ready` valid from N+2.
- **Single pop:** one pop per request, however long `i_request` is held.
- **Response hold:** `o_rdata` stays stable until the next R_POP.
- **Sync delay:** 2 cycles from a `UART_RX` edge to `rx_s`.
- **Bit sampling:**
  - The start bit is sampled about half a bit after it is detected.
  - Data bit k is sampled about (1.5+k)×bit time after the falling edge.
- **Buffer visibility:** a byte is pushed in the cycle the stop bit is sampled and is poppable by an R_POP in the next cycle.
- **Throughput:** back-to-back frames are accepted. IDLE re-arms in the cycle after STOP.

## Structure
- **Package `uart_pkg`:**
  - `rx_state_t` enum: IDLE, START, DATA, STOP, BREAK.
  - `rd_state_t` enum: R_IDLE, R_POP, R_RESP.
  - Status bit indices `RX_VALID_BIT`=8, `RX_OVERRUN_BIT`=9, `RX_FRAME_BIT`=10.
  - Default-PRESCALE helper function.
- **Sub-module `uart_rx_deserializer`:** synchroniser, tick counter and receive FSM. Outputs a one-cycle `byte_valid` plus `byte_data[7:0]` and a `frame_err` pulse.
- **Top level:** circular buffer with log2(DEPTH)+1-bit count, read FSM, and flags.

## Test plan
Bench uses PRESCALE=4, so one bit time is 32 clocks, and DEPTH=16.
- **Single byte:** drive frame 0xA5, then read → `o_rdata`=0x0000_01A5 and `o_ready` high 2 cycles after request.
- **Empty read:** read with nothing received → `o_rdata`=0x0000_0000 and `o_ready` at N+2. Holding `i_request` for 10 cycles gives exactly one response and no pointer change.
- **Glitch rejection:** drive `UART_RX` low for 8 clocks only (less than half a bit = 16) → no byte pushed and FSM back in IDLE. A following 0x3C frame reads back as 0x0000_013C.
- **Framing error:** frame 0x5A with stop bit 0, line held low for 100 clocks, then high, then frame 0x55. First read → 0x0000_0555 (framing + valid). Second read → 0x0000_0000.
- **Overrun:** send 17 frames 0x00..0x10 with no reads. First read → 0x0000_0300. Reads 2..16 → 0x101..0x10F, flags clear. 17th read → valid=0.
- **Reset mid-frame:** pulse `i_reset` for 1 cycle during data bit 3 of frame 0x81 → `o_ready`=0 and a read returns 0. A subsequent clean frame 0x7E reads back as 0x0000_017E.
